reg_master: RTL and testbench

//  Bus initiator for the sel/wr/addr/wdata/rdata/ready register-controller interface.

---
 rtl/reg_master_if.sv | 36 +++
 rtl/reg_master.sv | 129 ++++++++++++
 tb/tb_reg_master.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_master_if.sv
// Command, response and register-bus signals of the reg_master initiator.
interface reg_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_wr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  sel;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    // reg_master's own view
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
        output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, sel, wr, addr, wdata
    );

    // agent + responder view
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
        input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, sel, wr, addr, wdata
    );
endinterface

// File: rtl/reg_master.sv
// Register-bus initiator: takes one command at a time, runs the sel/ready bus
// sequence (with optional stall timeout) and returns a held response.
module reg_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_master_if.master ifc
);
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  timeout_hit;
    logic                  cnt_sat;
    logic                  sel_nxt, wr_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  rsp_valid_nxt, rsp_wr_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    assign ifc.cmd_ready = rst_n & (state == IDLE);
    assign timeout_hit   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign cnt_sat       = (cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ifc.cmd_valid) state_nxt = REQ;
            REQ: begin
                if (ifc.ready)        state_nxt = ifc.wr ? RESP : RDATA;
                else if (timeout_hit) state_nxt = RESP;
            end
            RDATA:   state_nxt = RESP;
            RESP:    if (ifc.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus/response outputs and stall counter
    always_comb begin
        sel_nxt       = ifc.sel;
        wr_nxt        = ifc.wr;
        addr_nxt      = ifc.addr;
        wdata_nxt     = ifc.wdata;
        rsp_valid_nxt = ifc.rsp_valid;
        rsp_wr_nxt    = ifc.rsp_wr;
        rsp_rdata_nxt = ifc.rsp_rdata;
        rsp_err_nxt   = ifc.rsp_err;
        cnt_nxt       = '0;
        case (state)
            IDLE: begin
                if (ifc.cmd_valid) begin
                    sel_nxt   = 1'b1;
                    wr_nxt    = ifc.cmd_wr;
                    addr_nxt  = ifc.cmd_addr;
                    wdata_nxt = ifc.cmd_wdata;
                end
            end
            REQ: begin
                if (ifc.ready) begin
                    // a read keeps sel up through the responder's recover cycle
                    if (ifc.wr) begin
                        sel_nxt       = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        rsp_wr_nxt    = 1'b1;
                        rsp_rdata_nxt = '0;
                        rsp_err_nxt   = 1'b0;
                    end
                end else if (timeout_hit) begin
                    sel_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_wr_nxt    = ifc.wr;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_sat ? cnt : cnt + CNT_W'(1);
                end
            end
            RDATA: begin
                sel_nxt       = 1'b0;
                rsp_valid_nxt = 1'b1;
                rsp_wr_nxt    = 1'b0;
                rsp_rdata_nxt = ifc.rdata;
                rsp_err_nxt   = 1'b0;
            end
            RESP: begin
                if (ifc.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            ifc.sel       <= 1'b0;
            ifc.wr        <= 1'b0;
            ifc.addr      <= '0;
            ifc.wdata     <= '0;
            ifc.rsp_valid <= 1'b0;
            ifc.rsp_wr    <= 1'b0;
            ifc.rsp_rdata <= '0;
            ifc.rsp_err   <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            ifc.sel       <= sel_nxt;
            ifc.wr        <= wr_nxt;
            ifc.addr      <= addr_nxt;
            ifc.wdata     <= wdata_nxt;
            ifc.rsp_valid <= rsp_valid_nxt;
            ifc.rsp_wr    <= rsp_wr_nxt;
            ifc.rsp_rdata <= rsp_rdata_nxt;
            ifc.rsp_err   <= rsp_err_nxt;
        end
    end
endmodule

// File: tb/tb_reg_master.sv
// Scoreboard bench for reg_master with a behavioural register responder.
module tb_reg_master;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    typedef struct packed {logic wr; logic [DW-1:0] rdata; logic err;} rsp_t;
    typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} bus_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif();
    reg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ifc(bif)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] resp_mem  [256];
    bit          force_stall = 1'b0;
    bit          rand_stall  = 1'b0;
    int          rsp_mode    = 0;
    int unsigned acc_cyc = 0, valid_cyc = 0;
    int unsigned acc_hist[$];
    int unsigned bus_accepts = 0, exp_accepts = 0;
    int          sel_run = 0, last_sel_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: decides the response and bus transfer each accepted command must produce
    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h1234;
        forever begin
            @(negedge clk);
            if (rst_n && bif.cmd_valid && bif.cmd_ready) begin
                acc_cyc = cyc;
                acc_hist.push_back(cyc);
                if (force_stall) begin
                    rsp_q.push_back(rsp_t'{bif.cmd_wr, 16'h0, 1'b1});
                end else begin
                    exp_accepts++;
                    bus_q.push_back(bus_t'{bif.cmd_wr, bif.cmd_addr, bif.cmd_wdata});
                    if (bif.cmd_wr) begin
                        model_mem[bif.cmd_addr] = bif.cmd_wdata;
                        rsp_q.push_back(rsp_t'{1'b1, 16'h0, 1'b0});
                    end else begin
                        rsp_q.push_back(rsp_t'{1'b0, model_mem[bif.cmd_addr], 1'b0});
                    end
                end
            end
        end
    end

    // Responder: one recover cycle (ready=0) after each read accept, optional stalls
    initial begin
        bit          acc;
        logic        a_wr;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        int          low;
        low = 0;
        for (int i = 0; i < 256; i++) resp_mem[i] = 16'h1234;
        bif.ready = 1'b1;
        bif.rdata = '0;
        forever begin
            @(negedge clk);
            acc     = rst_n && bif.sel && bif.ready;
            a_wr    = bif.wr;
            a_addr  = bif.addr;
            a_wdata = bif.wdata;
            @(posedge clk);
            #1;
            if (acc && a_wr) resp_mem[a_addr] = a_wdata;
            if (acc && !a_wr) begin
                bif.rdata = resp_mem[a_addr];
                bif.ready = 1'b0;
            end else if (force_stall) begin
                bif.ready = 1'b0;
            end else if (rand_stall && low < 2 && $urandom_range(3) == 0) begin
                bif.ready = 1'b0;
                low++;
            end else begin
                bif.ready = 1'b1;
                low = 0;
            end
        end
    end

    initial begin
        bif.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       bif.rsp_ready = 1'b1;
                1:       bif.rsp_ready = ($urandom_range(3) != 0);
                default: bif.rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor: pops the scoreboard and checks hold-while-stalled
    initial begin
        bit   prev_hold, prev_valid;
        rsp_t prev, cur, exp;
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = rsp_t'{bif.rsp_wr, bif.rsp_rdata, bif.rsp_err};
            if (!rst_n) begin
                rsp_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("rsp_hold_valid", 32'(bif.rsp_valid), 32'd1);
                    check("rsp_hold_data", 32'(cur), 32'(prev));
                    check("cmd_ready_in_resp", 32'(bif.cmd_ready), 32'd0);
                end
                if (bif.rsp_valid && !prev_valid) valid_cyc = cyc;
                if (bif.rsp_valid && bif.rsp_ready) begin
                    if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                    else begin
                        exp = rsp_q.pop_front();
                        check("rsp_wr", 32'(cur.wr), 32'(exp.wr));
                        check("rsp_rdata", 32'(cur.rdata), 32'(exp.rdata));
                        check("rsp_err", 32'(cur.err), 32'(exp.err));
                    end
                end
                prev_hold = bif.rsp_valid && !bif.rsp_ready;
                prev      = cur;
            end
            prev_valid = bif.rsp_valid;
        end
    end

    // Bus monitor: every sel&ready accept must match the next expected transfer
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (bif.sel) sel_run++;
            else if (sel_run != 0) begin
                last_sel_run = sel_run;
                sel_run = 0;
            end
            if (!rst_n) bus_q.delete();
            else if (bif.sel && bif.ready) begin
                bus_accepts++;
                if (bus_q.size() == 0) fail_now("bus_unexpected_accept");
                else begin
                    e = bus_q.pop_front();
                    check("bus_wr", 32'(bif.wr), 32'(e.wr));
                    check("bus_addr", 32'(bif.addr), 32'(e.addr));
                    if (e.wr) check("bus_wdata", 32'(bif.wdata), 32'(e.wdata));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = w;
        bif.cmd_addr  = a;
        bif.cmd_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bif.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("cmd_accept_timeout");
        @(posedge clk);
        #1;
        if (!keep) bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && !bif.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("rsp_wait_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        bif.cmd_valid = 1'b0;
        bif.cmd_wr    = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        check("rst_sel", 32'(bif.sel), 32'd0);
        check("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
        check("rst_addr", 32'(bif.addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Read after reset returns the controller reset value
        do_cmd(1'b0, 8'h05, 16'h0, 1'b0);
        wait_rsp();
        check("rd_latency", valid_cyc - acc_cyc, 32'd3);
        check("rd_sel_cycles", 32'(last_sel_run), 32'd2);
        check("ready_recovered", 32'(bif.ready), 32'd1);

        // Write then read back
        do_cmd(1'b1, 8'h10, 16'hBEEF, 1'b0);
        wait_rsp();
        check("wr_latency", valid_cyc - acc_cyc, 32'd2);
        check("wr_sel_cycles", 32'(last_sel_run), 32'd1);
        do_cmd(1'b0, 8'h10, 16'h0, 1'b0);
        wait_rsp();

        // Back-to-back with cmd_valid held
        acc_hist.delete();
        do_cmd(1'b1, 8'h01, 16'h0001, 1'b1);
        do_cmd(1'b0, 8'h01, 16'h0, 1'b1);
        do_cmd(1'b0, 8'h02, 16'h0, 1'b0);
        wait_rsp();
        check("b2b_accepts", acc_hist.size(), 32'd3);
        if (acc_hist.size() >= 3) begin
            check("b2b_write_gap", acc_hist[1] - acc_hist[0], 32'd3);
            check("b2b_read_gap", acc_hist[2] - acc_hist[1], 32'd4);
        end

        // Response backpressure for 10 cycles
        rsp_mode = 2;
        do_cmd(1'b0, 8'h10, 16'h0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.rsp_valid) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("bp_rsp_timeout");
        repeat (10) @(negedge clk);
        check("bp_rsp_valid", 32'(bif.rsp_valid), 32'd1);
        check("bp_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        check("bp_rdata", 32'(bif.rsp_rdata), 32'hBEEF);
        rsp_mode = 0;
        wait_rsp();

        // Responder stuck: read must abort with an error after TO stalled cycles
        force_stall = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(1'b0, 8'h33, 16'h0, 1'b0);
        wait_rsp();
        check("to_sel_cycles", 32'(last_sel_run), 32'(TO));
        force_stall = 1'b0;
        @(posedge clk);
        #1;
        do_cmd(1'b1, 8'h20, 16'hA5A5, 1'b0);
        wait_rsp();
        do_cmd(1'b0, 8'h20, 16'h0, 1'b0);
        wait_rsp();

        // Reset during the read-data cycle
        do_cmd(1'b0, 8'h01, 16'h0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bif.sel && !bif.ready) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("rdata_cycle_not_seen");
        rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(bif.sel), 32'd0);
        check("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(1'b0, 8'h10, 16'h0, 1'b0);
        wait_rsp();

        // Random traffic with responder stalls and response backpressure
        rand_stall = 1'b1;
        rsp_mode   = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
            do_cmd(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom), 1'b0);
        end
        wait_rsp();
        check("total_bus_accepts", bus_accepts, exp_accepts);
        check("bus_q_empty", bus_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
